// File: rtl/lvds_frame_rx_pkg.sv
// ---------------------------------------------------------------------------
// lvds_frame_rx_pkg
// Shared definitions for the LVDS frame receiver:
//   - default channel count / bits per channel
//   - serial line levels for start and stop bits
//   - 3-bit FSM state encodings and the state enum built from them
// Optional feature macro used by the receiver: LVDS_PARITY_EN
// ---------------------------------------------------------------------------
package lvds_frame_rx_pkg;

    localparam int LVDS_CH_NUM_DEFAULT    = 2;
    localparam int LVDS_BUFF_SIZE_DEFAULT = 8;

    localparam logic START_BIT_LEVEL = 1'b0;
    localparam logic STOP_BIT_LEVEL  = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PAR    = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_RESYNC = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_DATA   = ST_DATA,
        S_PAR    = ST_PAR,
        S_STOP   = ST_STOP,
        S_RESYNC = ST_RESYNC
    } lvds_rx_state_t;

endpackage

// File: rtl/lvds_shift_in.sv
// ---------------------------------------------------------------------------
// lvds_shift_in
// W-bit serial-in shift register with a payload bit counter.
// Ports:
//   clk      clock
//   rst      synchronous reset, active-high (clears register and counter)
//   i_clear  clear the bit counter (start of a new frame)
//   i_shift  shift i_bit in and advance the counter
//   i_bit    serial data bit
//   o_data   current shift register contents
//   o_done   high in the cycle the W-th bit is being shifted in
// MSB_FIRST = 0: new bit enters bit W-1 and the register moves toward the LSB,
//                so the first bit received ends up in bit 0.
// MSB_FIRST = 1: new bit enters bit 0 and the register moves toward the MSB,
//                so the first bit received ends up in bit W-1.
// ---------------------------------------------------------------------------
module lvds_shift_in #(
    parameter int W         = 16,
    parameter int MSB_FIRST = 0
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_shift,
    input  logic         i_bit,
    output logic [W-1:0] o_data,
    output logic         o_done
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_sr;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  w_sr_next;

    // Per-bit neighbour selection for the shift direction.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            if (MSB_FIRST != 0) begin : g_msb
                if (gi == 0) begin : g_in
                    assign w_sr_next[gi] = i_bit;
                end else begin : g_mv
                    assign w_sr_next[gi] = r_sr[gi-1];
                end
            end else begin : g_lsb
                if (gi == W - 1) begin : g_in
                    assign w_sr_next[gi] = i_bit;
                end else begin : g_mv
                    assign w_sr_next[gi] = r_sr[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_shift) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (i_shift) begin
                r_sr <= w_sr_next;
            end
        end
    end

    assign o_data = r_sr;
    assign o_done = i_shift && (r_cnt == CW'(W - 1));

endmodule

// File: rtl/lvds_frame_rx.sv
// ---------------------------------------------------------------------------
// lvds_frame_rx
// Serial frame receiver: start bit (0), W = CH_NUM*BUFF_SIZE payload bits,
// optional even-parity bit, stop bit (1). One bit sampled per clk.
// Ports:
//   clk         clock, rx sampled on the rising edge
//   rst         synchronous reset, active-high
//   rx          serial line, idles high
//   data_out    received payload, held until accepted
//   data_valid  data_out holds an unaccepted word
//   data_ready  consumer accepts when data_valid & data_ready
//   busy        receiver is in any state other than IDLE
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: new word dropped, previous still pending
//   parity_err  (LVDS_PARITY_EN only) one-cycle pulse: parity mismatch
//   err_cnt     saturating count of cycles carrying any error pulse
// Build option: define LVDS_PARITY_EN to add the parity bit, PAR state and
// the parity_err port (frame length W+3 instead of W+2).
// ---------------------------------------------------------------------------
module lvds_frame_rx
    import lvds_frame_rx_pkg::*;
#(
    parameter int CH_NUM    = LVDS_CH_NUM_DEFAULT,
    parameter int BUFF_SIZE = LVDS_BUFF_SIZE_DEFAULT,
    parameter int MSB_FIRST = 0,
    parameter int ERR_CNT_W = 8
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    output logic [CH_NUM*BUFF_SIZE-1:0] data_out,
    output logic                        data_valid,
    input  logic                        data_ready,
    output logic                        busy,
    output logic                        frame_err,
    output logic                        overrun,
`ifdef LVDS_PARITY_EN
    output logic                        parity_err,
`endif
    output logic [ERR_CNT_W-1:0]        err_cnt
);

    localparam int W = CH_NUM * BUFF_SIZE;

    lvds_rx_state_t r_state;
    lvds_rx_state_t w_state_next;

    logic [W-1:0]         r_data_out;
    logic                 r_data_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic         w_clear;
    logic         w_shift;
    logic         w_done;
    logic [W-1:0] w_sr;
    logic         w_stop_good;
    logic         w_stop_bad;
    logic         w_parity_bad;
    logic         w_parity_err;
    logic         w_word_ok;
    logic         w_accept;
    logic         w_overrun;
    logic         w_any_err;

    lvds_shift_in #(
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_in (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_shift (w_shift),
        .i_bit   (rx),
        .o_data  (w_sr),
        .o_done  (w_done)
    );

`ifdef LVDS_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bit <= 1'b0;
        end else if (r_state == S_PAR) begin
            r_par_bit <= rx;
        end
    end

    // Even parity: payload bits plus parity bit must XOR to zero.
    assign w_parity_bad = ^{w_sr, r_par_bit};
`else
    assign w_parity_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_shift      = 1'b0;
        w_stop_good  = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx == START_BIT_LEVEL) begin
                    w_clear      = 1'b1;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_shift = 1'b1;
                if (w_done) begin
`ifdef LVDS_PARITY_EN
                    w_state_next = S_PAR;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef LVDS_PARITY_EN
            S_PAR: begin
                w_state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (rx == STOP_BIT_LEVEL) begin
                    w_stop_good  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_stop_bad   = 1'b1;
                    w_state_next = S_RESYNC;
                end
            end
            S_RESYNC: begin
                // Hold off until the line returns high so a stuck-low line
                // cannot be mistaken for a stream of start bits.
                if (rx == STOP_BIT_LEVEL) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // A bad stop bit masks any parity result for the same frame.
    assign w_parity_err = w_stop_good & w_parity_bad;
    assign w_word_ok    = w_stop_good & ~w_parity_bad;
    // The pending word can be replaced in the same cycle it is accepted.
    assign w_accept     = w_word_ok & (~r_data_valid | data_ready);
    assign w_overrun    = w_word_ok & r_data_valid & ~data_ready;
    assign w_any_err    = w_stop_bad | w_parity_err | w_overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_overrun;
            if (w_accept) begin
                r_data_out   <= w_sr;
                r_data_valid <= 1'b1;
            end else if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end
            if (w_any_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

`ifdef LVDS_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_parity_err;
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign busy       = (r_state != S_IDLE);
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_lvds_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_lvds_frame_rx
// Two receivers share one serial line and handshake: u_dut0 (LSB-first,
// 8-bit error counter) and u_dut1 (MSB-first, 3-bit error counter so that
// saturation is reached). The reference model works at frame level: the
// bench knows which cycle carries a stop bit and which word it closes, and
// applies the commit / overrun / handshake rules to a single pending word.
// Honours LVDS_PARITY_EN (adds the parity bit and parity_err checks).
// ---------------------------------------------------------------------------
module tb_lvds_frame_rx;

    localparam int W = 16;
`ifdef LVDS_PARITY_EN
    localparam int FLEN = W + 3;
`else
    localparam int FLEN = W + 2;
`endif

    localparam int K_IDLE      = 0;
    localparam int K_BIT       = 1;
    localparam int K_STOP_OK   = 2;
    localparam int K_STOP_BAD  = 3;
    localparam int K_STOP_PBAD = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx = 1'b1;
    logic         data_ready = 1'b0;
    logic [W-1:0] dout0, dout1;
    logic         dv0, dv1, busy0, busy1, fe0, fe1, ov0, ov1;
    logic [7:0]   ec0;
    logic [2:0]   ec1;
`ifdef LVDS_PARITY_EN
    logic         pe0, pe1;
`endif

    always #5 clk = ~clk;

    lvds_frame_rx #(.CH_NUM(2), .BUFF_SIZE(8), .MSB_FIRST(0), .ERR_CNT_W(8)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (dout0),
        .data_valid (dv0),
        .data_ready (data_ready),
        .busy       (busy0),
        .frame_err  (fe0),
        .overrun    (ov0),
`ifdef LVDS_PARITY_EN
        .parity_err (pe0),
`endif
        .err_cnt    (ec0)
    );

    lvds_frame_rx #(.CH_NUM(2), .BUFF_SIZE(8), .MSB_FIRST(1), .ERR_CNT_W(3)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (dout1),
        .data_valid (dv1),
        .data_ready (data_ready),
        .busy       (busy1),
        .frame_err  (fe1),
        .overrun    (ov1),
`ifdef LVDS_PARITY_EN
        .parity_err (pe1),
`endif
        .err_cnt    (ec1)
    );

    // Model state
    logic         m_valid;
    logic [W-1:0] m_word;
    int           m_cnt0, m_cnt1;
    int           ready_mode;   // 0 = low, 1 = high, 2 = random per cycle
    int           n_vec = 0;
    int           n_bad = 0;
    int           n_frames = 0;

    // Time of the last change of dout0, for the back-to-back spacing check.
    logic [W-1:0] mon_prev = '0;
    longint       mon_t_last = 0;
    always @(negedge clk) begin
        if (dout0 !== mon_prev) mon_t_last = $time;
        mon_prev = dout0;
    end

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[W-1-i] = v[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs(input logic eb, input logic efe, input logic eov, input logic epe);
        chk("dv0",   32'(dv0),   32'(m_valid));
        chk("dv1",   32'(dv1),   32'(m_valid));
        chk("dout0", 32'(dout0), 32'(m_word));
        chk("dout1", 32'(dout1), 32'(rev(m_word)));
        chk("busy0", 32'(busy0), 32'(eb));
        chk("busy1", 32'(busy1), 32'(eb));
        chk("fe0",   32'(fe0),   32'(efe));
        chk("fe1",   32'(fe1),   32'(efe));
        chk("ov0",   32'(ov0),   32'(eov));
        chk("ov1",   32'(ov1),   32'(eov));
`ifdef LVDS_PARITY_EN
        chk("pe0",   32'(pe0),   32'(epe));
        chk("pe1",   32'(pe1),   32'(epe));
`else
        if (epe) chk("pe_unexpected", 32'(epe), 32'(0));
`endif
        chk("ec0",   32'(ec0),   32'(m_cnt0));
        chk("ec1",   32'(ec1),   32'(m_cnt1));
    endtask

    // One serial bit time; kind tells the model what this bit means.
    task automatic cycle(input logic b, input int kind, input logic [W-1:0] word);
        logic rdy;
        logic efe, eov, epe, eb;
        if (ready_mode == 2) rdy = 1'($urandom_range(0, 1));
        else                 rdy = (ready_mode == 1);
        rx         = b;
        data_ready = rdy;
        efe = (kind == K_STOP_BAD);
        epe = (kind == K_STOP_PBAD);
        eov = 1'b0;
        if (kind == K_STOP_OK && (!m_valid || rdy)) begin
            m_valid = 1'b1;
            m_word  = word;
        end else begin
            if (kind == K_STOP_OK) eov = 1'b1;
            if (m_valid && rdy) m_valid = 1'b0;
        end
        if (efe || eov || epe) begin
            if (m_cnt0 < 255) m_cnt0++;
            if (m_cnt1 < 7)   m_cnt1++;
        end
        eb = !(kind == K_IDLE || kind == K_STOP_OK || kind == K_STOP_PBAD);
        @(posedge clk);
        #1;
        check_outputs(eb, efe, eov, epe);
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic stop_ok, input logic par_ok);
        logic par_eff;
`ifdef LVDS_PARITY_EN
        par_eff = par_ok;
`else
        par_eff = 1'b1;
`endif
        n_frames++;
        $display("frame %0d: word=%h stop_ok=%0d parity_ok=%0d ready_mode=%0d",
                 n_frames, word, stop_ok, par_eff, ready_mode);
        cycle(1'b0, K_BIT, word);
        for (int i = 0; i < W; i++) cycle(word[i], K_BIT, word);
`ifdef LVDS_PARITY_EN
        cycle((^word) ^ ~par_ok, K_BIT, word);
`endif
        if (!stop_ok)     cycle(1'b0, K_STOP_BAD, word);
        else if (par_eff) cycle(1'b1, K_STOP_OK, word);
        else              cycle(1'b1, K_STOP_PBAD, word);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        rx         = 1'b1;
        data_ready = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_valid = 1'b0;
        m_word  = '0;
        m_cnt0  = 0;
        m_cnt1  = 0;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] exp_lsb;
        logic [W-1:0] exp_msb;
    } vec_t;

    vec_t   tbl[4];
    longint t_commit[4];

    initial begin
        tbl[0] = '{word: 16'hA55A, exp_lsb: 16'hA55A, exp_msb: 16'h5AA5};
        tbl[1] = '{word: 16'h1234, exp_lsb: 16'h1234, exp_msb: 16'h2C48};
        tbl[2] = '{word: 16'hBEEF, exp_lsb: 16'hBEEF, exp_msb: 16'hF77D};
        tbl[3] = '{word: 16'h00FF, exp_lsb: 16'h00FF, exp_msb: 16'hFF00};

        ready_mode = 1;
        do_reset();
        cycle(1'b1, K_IDLE, '0);

        // Table: back-to-back frames, consumer always ready.
        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].word, 1'b1, 1'b1);
            t_commit[i] = mon_t_last;
            chk("tbl_lsb",   32'(dout0), 32'(tbl[i].exp_lsb));
            chk("tbl_msb",   32'(dout1), 32'(tbl[i].exp_msb));
            chk("tbl_valid", 32'(dv0),   32'(1));
        end
        chk("b2b_gap", 32'(t_commit[2] - t_commit[1]), 32'(FLEN * 10));
        cycle(1'b1, K_IDLE, '0);

        // Framing error followed by a stuck-low line.
        do_reset();
        send_frame(16'h3C3C, 1'b0, 1'b1);
        chk("fe_pulse", 32'(fe0), 32'(1));
        for (int i = 0; i < 5; i++) cycle(1'b0, K_BIT, '0);
        for (int i = 0; i < 3; i++) cycle(1'b1, K_IDLE, '0);
        chk("fe_cnt",    32'(ec0), 32'(1));
        chk("fe_nvalid", 32'(dv0), 32'(0));

        // Overrun with the consumer stalled.
        do_reset();
        ready_mode = 0;
        send_frame(16'h0001, 1'b1, 1'b1);
        send_frame(16'h0002, 1'b1, 1'b1);
        chk("ovr_pulse", 32'(ov0),   32'(1));
        chk("ovr_data",  32'(dout0), 32'(16'h0001));
        chk("ovr_cnt",   32'(ec0),   32'(1));
        ready_mode = 1;
        cycle(1'b1, K_IDLE, '0);
        chk("ovr_drop",  32'(dv0),   32'(0));
        chk("ovr_hold",  32'(dout0), 32'(16'h0001));

        // Reset in the middle of a frame.
        do_reset();
        cycle(1'b0, K_BIT, '0);
        for (int i = 0; i < 7; i++) cycle(1'b1, K_BIT, '0);
        do_reset();
        send_frame(16'h00FF, 1'b1, 1'b1);
        chk("rst_data", 32'(dout0), 32'(16'h00FF));
        chk("rst_cnt",  32'(ec0),   32'(0));
`ifdef LVDS_PARITY_EN
        do_reset();
        send_frame(16'h00FF, 1'b1, 1'b0);
        chk("par_pulse",  32'(pe0), 32'(1));
        chk("par_nvalid", 32'(dv0), 32'(0));
`endif

        // Randomized traffic with random consumer back-pressure.
        do_reset();
        ready_mode = 2;
        for (int f = 0; f < 200; f++) begin
            logic [W-1:0] w;
            logic stop_ok, par_ok;
            w       = W'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            par_ok  = ($urandom_range(0, 5) != 0);
            send_frame(w, stop_ok, par_ok);
            if (!stop_ok) begin
                repeat ($urandom_range(0, 4)) cycle(1'b0, K_BIT, '0);
                cycle(1'b1, K_IDLE, '0);
            end
            repeat ($urandom_range(0, 2)) cycle(1'b1, K_IDLE, '0);
        end
        if (m_cnt1 == 7) chk("sat1", 32'(ec1), 32'(7));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
